conv_pixel_streamer: RTL and testbench

- Source side of the layer-1 pixel stream. Reads one IMG_WIDTH x IMG_HEIGHT frame from a single-port image RAM (1-cycle read latency) in raster order.
- Drives the accelerator's valid_in/pixel_in interface: one pixel per valid cycle, gaps allowed, no backpressure from the sink.
- Sits between the host-loaded image buffer and the convolution accelerator; the top-level controller sequences it with start/done.

---
 rtl/conv_pixel_streamer.sv | 141 ++++++++++++++
 tb/tb_conv_pixel_streamer.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_pixel_streamer.sv
// Streams one raster-order frame from a single-port image RAM (1-cycle read latency)
// onto the accelerator's valid/pixel interface, sequenced by start/done.
module conv_pixel_streamer #(
  parameter int unsigned IMG_WIDTH  = 28,
  parameter int unsigned IMG_HEIGHT = 28,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  pause,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] pixel_out,
  output logic                  row_last,
  output logic                  frame_last,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int unsigned ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e                  state_q, state_d;
  logic [COL_W-1:0]        col_q, col_d;
  logic [ROW_W-1:0]        row_q, row_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    rd_issue;
  logic                    last_col, last_row;

  // Stage 1: read in flight (RAM data appears this cycle).
  logic                    s1_valid_q, s1_row_last_q, s1_frame_last_q;
  // Stage 2: registered pixel presented to the accelerator.
  logic                    valid_q, row_last_q, frame_last_q;
  logic [DATA_WIDTH-1:0]   pixel_q;

  assign last_col = (col_q == COL_MAX);
  assign last_row = (row_q == ROW_MAX);

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    addr_d   = addr_q;
    rd_issue = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          col_d   = '0;
          row_d   = '0;
          addr_d  = base_addr;
        end
      end
      StRun: begin
        if (!pause) begin
          rd_issue = 1'b1;
          // Raster order makes base + row*W + col a simple running increment.
          addr_d   = addr_q + 1'b1;
          if (last_col) begin
            col_d = '0;
            if (last_row) begin
              row_d   = '0;
              state_d = StDrain;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      StDrain: begin
        if (valid_q && frame_last_q) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      col_q   <= '0;
      row_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q      <= 1'b0;
      s1_row_last_q   <= 1'b0;
      s1_frame_last_q <= 1'b0;
      valid_q         <= 1'b0;
      row_last_q      <= 1'b0;
      frame_last_q    <= 1'b0;
      pixel_q         <= '0;
    end else begin
      s1_valid_q      <= rd_issue;
      s1_row_last_q   <= rd_issue && last_col;
      s1_frame_last_q <= rd_issue && last_col && last_row;
      valid_q         <= s1_valid_q;
      row_last_q      <= s1_valid_q && s1_row_last_q;
      frame_last_q    <= s1_valid_q && s1_frame_last_q;
      // Hold the last pixel across gaps.
      if (s1_valid_q) begin
        pixel_q <= mem_rdata;
      end
    end
  end

  assign mem_rd_en  = rd_issue;
  assign mem_addr   = addr_q;
  assign valid_out  = valid_q;
  assign pixel_out  = pixel_q;
  assign row_last   = row_last_q;
  assign frame_last = frame_last_q;
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);

endmodule

// File: tb/tb_conv_pixel_streamer.sv
// Directed bench for conv_pixel_streamer: RAM model mem[a] = a[7:0], default 28x28 frame.
module tb_conv_pixel_streamer;

  localparam int N = 784;

  logic       clk = 1'b0;
  logic       rst, start, pause;
  logic [9:0] base_addr;
  logic       mem_rd_en;
  logic [9:0] mem_addr;
  logic [7:0] mem_rdata = '0;
  logic       valid_out;
  logic [7:0] pixel_out;
  logic       row_last, frame_last, busy, done;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  conv_pixel_streamer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .pause      (pause),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .valid_out  (valid_out),
    .pixel_out  (pixel_out),
    .row_last   (row_last),
    .frame_last (frame_last),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem_addr[7:0];

  // Output logs, sampled on the falling edge.
  logic [7:0] pix_q[$];
  bit         rl_q[$];
  bit         fl_q[$];
  int         vcyc_q[$];
  logic [9:0] addr_q[$];
  int         rdcyc_q[$];
  int         done_q[$];
  int         busy_cnt = 0;
  bit         log_clr  = 1'b0;

  always @(negedge clk) begin
    if (log_clr) begin
      pix_q.delete(); rl_q.delete(); fl_q.delete(); vcyc_q.delete();
      addr_q.delete(); rdcyc_q.delete(); done_q.delete();
      busy_cnt <= 0;
    end else begin
      if (valid_out) begin
        pix_q.push_back(pixel_out);
        rl_q.push_back(row_last);
        fl_q.push_back(frame_last);
        vcyc_q.push_back(cyc);
      end
      if (mem_rd_en) begin
        addr_q.push_back(mem_addr);
        rdcyc_q.push_back(cyc);
      end
      if (done) done_q.push_back(cyc);
      if (busy) busy_cnt <= busy_cnt + 1;
    end
  end

  task automatic clear_logs();
    @(negedge clk);
    #1 log_clr = 1'b1;
    @(negedge clk);
    #1 log_clr = 1'b0;
  endtask

  task automatic wait_done(output bit to);
    to = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (done) begin
        to = 1'b0;
        break;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run_frame(input logic [9:0] b, output int s, output bit to);
    clear_logs();
    @(posedge clk);
    #1 base_addr = b; start = 1'b1; s = cyc;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(to);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; pause = 1'b0; base_addr = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_assert++;
    if ({valid_out, row_last, frame_last, busy, done, mem_rd_en} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 000000", {valid_out, row_last, frame_last, busy, done, mem_rd_en});
    end
    n_assert++;
    if (pixel_out !== 8'd0) begin
      n_fail++; $display("FAIL reset_pixel: got %0d expected 0", pixel_out);
    end
    n_assert++;
    if (mem_addr !== 10'd0) begin
      n_fail++; $display("FAIL reset_addr: got %0d expected 0", mem_addr);
    end
  endtask

  task automatic test_basic_frame();
    int s; bit to;
    run_frame(10'd0, s, to);
    n_assert++;
    if (to !== 1'b0) begin n_fail++; $display("FAIL basic_timeout: done never seen"); end
    n_assert++;
    if (pix_q.size() !== N) begin
      n_fail++; $display("FAIL basic_count: got %0d expected %0d", pix_q.size(), N);
    end
    for (int i = 0; i < pix_q.size(); i++) begin
      n_assert++;
      if (pix_q[i] !== 8'(i)) begin
        n_fail++; $display("FAIL basic_pixel[%0d]: got %0d expected %0d", i, pix_q[i], 8'(i));
      end
    end
    n_assert++;
    if (rdcyc_q[0] !== s + 1) begin
      n_fail++; $display("FAIL basic_first_rd: got cycle %0d expected %0d", rdcyc_q[0], s + 1);
    end
    n_assert++;
    if (vcyc_q[0] !== s + 3) begin
      n_fail++; $display("FAIL basic_first_valid: got cycle %0d expected %0d", vcyc_q[0], s + 3);
    end
    n_assert++;
    if (vcyc_q[N-1] !== s + 786) begin
      n_fail++; $display("FAIL basic_last_valid: got cycle %0d expected %0d", vcyc_q[N-1], s + 786);
    end
    n_assert++;
    if (done_q.size() !== 1 || done_q[0] !== s + 787) begin
      n_fail++; $display("FAIL basic_done: got %0d pulses at %0d expected 1 at %0d", done_q.size(), done_q[0], s + 787);
    end
    n_assert++;
    if (busy_cnt !== 787) begin
      n_fail++; $display("FAIL basic_busy_cycles: got %0d expected 787", busy_cnt);
    end
    n_assert++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_row_frame_last();
    int s; bit to; int nrl;
    run_frame(10'd0, s, to);
    nrl = 0;
    n_assert++;
    if (to !== 1'b0 || rl_q.size() !== N) begin
      n_fail++; $display("FAIL last_frame_len: got %0d expected %0d", rl_q.size(), N);
    end
    for (int i = 0; i < rl_q.size(); i++) begin
      if (rl_q[i]) nrl++;
      n_assert++;
      if (rl_q[i] !== ((i % 28) == 27) || fl_q[i] !== (i == N - 1)) begin
        n_fail++;
        $display("FAIL last_flags[%0d]: got rl=%b fl=%b expected rl=%b fl=%b",
                 i, rl_q[i], fl_q[i], (i % 28) == 27, i == N - 1);
      end
    end
    n_assert++;
    if (nrl !== 28) begin n_fail++; $display("FAIL row_last_count: got %0d expected 28", nrl); end
  endtask

  task automatic test_pause();
    int s; bit to;
    clear_logs();
    @(posedge clk);
    #1 base_addr = '0; start = 1'b1; s = cyc;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (100) @(posedge clk);
    #1 pause = 1'b1;
    repeat (5) @(posedge clk);
    #1 pause = 1'b0;
    wait_done(to);
    n_assert++;
    if (to !== 1'b0 || pix_q.size() !== N) begin
      n_fail++; $display("FAIL pause_count: got %0d expected %0d", pix_q.size(), N);
    end
    for (int i = 0; i < pix_q.size(); i++) begin
      n_assert++;
      if (pix_q[i] !== 8'(i)) begin
        n_fail++; $display("FAIL pause_pixel[%0d]: got %0d expected %0d", i, pix_q[i], 8'(i));
      end
    end
    n_assert++;
    if (vcyc_q[99] !== s + 102 || vcyc_q[100] !== s + 108) begin
      n_fail++;
      $display("FAIL pause_gap: got cycles %0d,%0d expected %0d,%0d", vcyc_q[99], vcyc_q[100], s + 102, s + 108);
    end
    n_assert++;
    if (vcyc_q[N-1] !== s + 791) begin
      n_fail++; $display("FAIL pause_last_valid: got cycle %0d expected %0d", vcyc_q[N-1], s + 791);
    end
    n_assert++;
    if (done_q[0] !== s + 792) begin
      n_fail++; $display("FAIL pause_done: got cycle %0d expected %0d", done_q[0], s + 792);
    end
  endtask

  // Also covers start with pause high: accepted, reads wait for pause low.
  task automatic test_base_addr();
    int s; bit to;
    clear_logs();
    @(posedge clk);
    #1 base_addr = 10'd100; start = 1'b1; pause = 1'b1; s = cyc;
    @(posedge clk);
    #1 start = 1'b0; base_addr = 10'd0;
    @(posedge clk);
    @(posedge clk);
    #1 pause = 1'b0;
    wait_done(to);
    n_assert++;
    if (to !== 1'b0 || addr_q.size() !== N) begin
      n_fail++; $display("FAIL base_rd_count: got %0d expected %0d", addr_q.size(), N);
    end
    n_assert++;
    if (addr_q[0] !== 10'd100 || addr_q[N-1] !== 10'd883) begin
      n_fail++; $display("FAIL base_addr_range: got %0d..%0d expected 100..883", addr_q[0], addr_q[N-1]);
    end
    n_assert++;
    if (rdcyc_q[0] !== s + 3 || vcyc_q[0] !== s + 5) begin
      n_fail++;
      $display("FAIL base_start_pause: got rd %0d valid %0d expected %0d %0d", rdcyc_q[0], vcyc_q[0], s + 3, s + 5);
    end
    n_assert++;
    if (pix_q[0] !== 8'd100 || pix_q[N-1] !== 8'd115) begin
      n_fail++; $display("FAIL base_pixels: got %0d..%0d expected 100..115", pix_q[0], pix_q[N-1]);
    end
    for (int i = 0; i < pix_q.size(); i++) begin
      n_assert++;
      if (pix_q[i] !== 8'(100 + i)) begin
        n_fail++; $display("FAIL base_pixel[%0d]: got %0d expected %0d", i, pix_q[i], 8'(100 + i));
      end
    end
    n_assert++;
    if (done_q[0] !== s + 789) begin
      n_fail++; $display("FAIL base_done: got cycle %0d expected %0d", done_q[0], s + 789);
    end
  endtask

  task automatic test_back_to_back();
    int s;
    clear_logs();
    @(posedge clk);
    #1 base_addr = '0; start = 1'b1; s = cyc;
    for (int c = 0; c < 1700; c++) begin
      @(posedge clk);
      #1 start = (cyc == s + 50) || (cyc == s + 787) || (cyc == s + 788);
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
    n_assert++;
    if (done_q.size() !== 2 || done_q[0] !== s + 787 || done_q[1] !== s + 1575) begin
      n_fail++;
      $display("FAIL b2b_done: got %0d pulses (%0d,%0d) expected 2 (%0d,%0d)",
               done_q.size(), done_q[0], done_q[1], s + 787, s + 1575);
    end
    n_assert++;
    if (pix_q.size() !== 2 * N) begin
      n_fail++; $display("FAIL b2b_count: got %0d expected %0d", pix_q.size(), 2 * N);
    end
    n_assert++;
    if (vcyc_q[N] !== s + 791 || pix_q[N] !== 8'd0 || pix_q[2*N-1] !== 8'd15) begin
      n_fail++;
      $display("FAIL b2b_second: got cycle %0d first %0d last %0d expected %0d 0 15",
               vcyc_q[N], pix_q[N], pix_q[2*N-1], s + 791);
    end
  endtask

  task automatic test_reset_mid_frame();
    int s, s2; bit to;
    clear_logs();
    @(posedge clk);
    #1 base_addr = '0; start = 1'b1; s = cyc;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1 start = 1'b0;
      if (cyc == s + 304) begin
        rst = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_assert++;
    if ({valid_out, busy, mem_rd_en, done} !== 4'b0) begin
      n_fail++; $display("FAIL rst_mid_outputs: got %b expected 0000", {valid_out, busy, mem_rd_en, done});
    end
    repeat (20) @(negedge clk);
    n_assert++;
    if (pix_q.size() !== 302 || done_q.size() !== 0) begin
      n_fail++; $display("FAIL rst_mid_stray: got %0d pixels %0d done expected 302 0", pix_q.size(), done_q.size());
    end
    run_frame(10'd0, s2, to);
    n_assert++;
    if (to !== 1'b0 || pix_q.size() !== N || pix_q[0] !== 8'd0 || addr_q[0] !== 10'd0) begin
      n_fail++;
      $display("FAIL rst_restart: got %0d pixels first %0d addr %0d expected %0d 0 0",
               pix_q.size(), pix_q[0], addr_q[0], N);
    end
    n_assert++;
    if (vcyc_q[0] !== s2 + 3) begin
      n_fail++; $display("FAIL rst_restart_latency: got cycle %0d expected %0d", vcyc_q[0], s2 + 3);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_row_frame_last();
    test_pause();
    test_base_addr();
    test_back_to_back();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
